// File: rtl/vx_ibuffer_issue_sched.sv
// ============================================================================
// Module  : vx_ibuffer_issue_sched
// Purpose : Round-robin scheduler popping per-warp ibuffer heads into one
//           registered valid/ready issue channel, with saturating perf counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module vx_ibuffer_issue_sched #(
  parameter  int NUM_WIS = 4,
  parameter  int DATA_W  = 128,
  parameter  int PERF_W  = 32,
  localparam int WIS_W   = (NUM_WIS > 1) ? $clog2(NUM_WIS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_WIS-1:0]        in_valid,
  input  logic [NUM_WIS*DATA_W-1:0] in_data,
  output logic [NUM_WIS-1:0]        in_ready,
  input  logic [NUM_WIS-1:0]        wis_mask,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [WIS_W-1:0]          out_wis,
  input  logic                      out_ready,
  output logic [PERF_W-1:0]         perf_issued,
  output logic [PERF_W-1:0]         perf_stalls
);

  localparam logic [WIS_W-1:0] c_LAST_WIS = WIS_W'(NUM_WIS - 1);

  logic [WIS_W-1:0]   r_rr_ptr;
  logic               r_out_valid;
  logic [DATA_W-1:0]  r_out_data;
  logic [WIS_W-1:0]   r_out_wis;
  logic [PERF_W-1:0]  r_perf_issued;
  logic [PERF_W-1:0]  r_perf_stalls;

  logic [NUM_WIS-1:0] w_eligible;
  logic [WIS_W-1:0]   w_grant;
  logic               w_any;
  logic               w_load;
  logic [WIS_W-1:0]   w_next_ptr;
  logic [DATA_W-1:0]  w_grant_data;
  int                 w_scan_idx;

  assign w_eligible = in_valid & wis_mask;

  // Cyclic scan starting at rr_ptr; explicit wrap keeps non-power-of-two counts correct.
  always_comb begin
    w_grant    = '0;
    w_any      = 1'b0;
    w_scan_idx = 0;
    for (int k = 0; k < NUM_WIS; k++) begin
      w_scan_idx = int'(r_rr_ptr) + k;
      if (w_scan_idx >= NUM_WIS) begin
        w_scan_idx = w_scan_idx - NUM_WIS;
      end
      if (!w_any && w_eligible[w_scan_idx]) begin
        w_any   = 1'b1;
        w_grant = WIS_W'(w_scan_idx);
      end
    end
  end

  assign w_load       = (!r_out_valid || out_ready) && w_any;
  assign w_next_ptr   = (w_grant == c_LAST_WIS) ? '0 : w_grant + 1'b1;
  assign w_grant_data = in_data[int'(w_grant)*DATA_W +: DATA_W];

  always_comb begin
    in_ready = '0;
    if (reset && w_load) begin
      in_ready[w_grant] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rr_ptr    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_wis   <= '0;
    end else if (w_load) begin
      r_rr_ptr    <= w_next_ptr;
      r_out_valid <= 1'b1;
      r_out_data  <= w_grant_data;
      r_out_wis   <= w_grant;
    end else if (out_ready) begin
      // Drained with nothing to refill: data/wis deliberately left stale.
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_perf_issued <= '0;
      r_perf_stalls <= '0;
    end else if (r_out_valid) begin
      if (out_ready && (r_perf_issued != '1)) begin
        r_perf_issued <= r_perf_issued + 1'b1;
      end
      if (!out_ready && (r_perf_stalls != '1)) begin
        r_perf_stalls <= r_perf_stalls + 1'b1;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_wis     = r_out_wis;
  assign perf_issued = r_perf_issued;
  assign perf_stalls = r_perf_stalls;

endmodule

`default_nettype wire

// File: tb/tb_vx_ibuffer_issue_sched.sv
// ============================================================================
// Module  : tb_vx_ibuffer_issue_sched
// Purpose : Directed bench for vx_ibuffer_issue_sched (4-warp and 3-warp builds).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_vx_ibuffer_issue_sched;

  localparam int N4 = 4;
  localparam int D4 = 32;
  localparam int N3 = 3;
  localparam int D3 = 8;
  localparam int PW = 4;

  logic            clk = 1'b0;
  logic            reset;

  logic [N4-1:0]   in_valid4, wis_mask4, in_ready4;
  logic [N4*D4-1:0] in_data4;
  logic            out_valid4, out_ready4;
  logic [D4-1:0]   out_data4;
  logic [1:0]      out_wis4;
  logic [PW-1:0]   perf_issued4, perf_stalls4;

  logic [N3-1:0]   in_valid3, wis_mask3, in_ready3;
  logic [N3*D3-1:0] in_data3;
  logic            out_valid3, out_ready3;
  logic [D3-1:0]   out_data3;
  logic [1:0]      out_wis3;
  logic [PW-1:0]   perf_issued3, perf_stalls3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vx_ibuffer_issue_sched #(.NUM_WIS(N4), .DATA_W(D4), .PERF_W(PW)) u_dut4 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid4), .in_data(in_data4), .in_ready(in_ready4),
    .wis_mask(wis_mask4),
    .out_valid(out_valid4), .out_data(out_data4), .out_wis(out_wis4),
    .out_ready(out_ready4),
    .perf_issued(perf_issued4), .perf_stalls(perf_stalls4)
  );

  vx_ibuffer_issue_sched #(.NUM_WIS(N3), .DATA_W(D3), .PERF_W(PW)) u_dut3 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
    .wis_mask(wis_mask3),
    .out_valid(out_valid3), .out_data(out_data3), .out_wis(out_wis3),
    .out_ready(out_ready3),
    .perf_issued(perf_issued3), .perf_stalls(perf_stalls3)
  );

  function automatic logic [D4-1:0] word4(input int w);
    return 32'hC0DE_0000 + 32'(w * 32'h111);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then let registered outputs settle before looking.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
  endtask

  initial begin
    for (int i = 0; i < N4; i++) in_data4[i*D4 +: D4] = word4(i);
    in_data3   = {8'h33, 8'h22, 8'h11};
    in_valid3  = '0;
    wis_mask3  = '1;
    out_ready3 = 1'b1;

    // Reset and idle, then full-rate round robin.
    reset = 1'b0; in_valid4 = 4'b1111; wis_mask4 = 4'b1111; out_ready4 = 1'b1;
    tick(); tick();
    check("rst_in_ready", 64'(in_ready4), 64'h0);
    check("rst_out_valid", 64'(out_valid4), 64'h0);
    check("rst_out_data", 64'(out_data4), 64'h0);
    check("rst_issued", 64'(perf_issued4), 64'h0);
    check("rst_stalls", 64'(perf_stalls4), 64'h0);
    reset = 1'b1; #1;
    check("t1_first_ready", 64'(in_ready4), 64'b0001);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t1_rr_wis", 64'(out_wis4), 64'(k % 4));
      check("t1_rr_data", 64'(out_data4), 64'(word4(k % 4)));
    end
    tick();
    check("t1_issued5", 64'(perf_issued4), 64'd5);

    // Backpressure holds the record and stalls the pop.
    do_reset();
    in_valid4 = 4'b0100; out_ready4 = 1'b1;
    tick();
    check("t2_load_wis", 64'(out_wis4), 64'd2);
    in_valid4 = 4'b1111; out_ready4 = 1'b0; #1;
    check("t2_bp_ready", 64'(in_ready4), 64'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t2_hold_wis", 64'(out_wis4), 64'd2);
      check("t2_hold_data", 64'(out_data4), 64'(word4(2)));
      check("t2_hold_ready", 64'(in_ready4), 64'h0);
    end
    check("t2_stalls3", 64'(perf_stalls4), 64'd3);
    out_ready4 = 1'b1; #1;
    check("t2_resume_ready", 64'(in_ready4), 64'b1000);
    tick();
    check("t2_next_wis", 64'(out_wis4), 64'd3);
    check("t2_next_data", 64'(out_data4), 64'(word4(3)));
    check("t2_issued1", 64'(perf_issued4), 64'd1);

    // Mask forces grant 0 from rr_ptr=1, pointer returns to 1.
    do_reset();
    in_valid4 = 4'b1111; wis_mask4 = 4'b0001;
    tick();
    check("t3_pre_wis", 64'(out_wis4), 64'd0);
    #1;
    check("t3_mask_ready", 64'(in_ready4), 64'b0001);
    tick();
    check("t3_mask_wis", 64'(out_wis4), 64'd0);
    wis_mask4 = 4'b1111; #1;
    check("t3_unmask_ready", 64'(in_ready4), 64'b0010);
    tick();
    check("t3_unmask_wis", 64'(out_wis4), 64'd1);

    // Drain with nothing eligible.
    do_reset();
    in_valid4 = 4'b0001;
    tick();
    check("t5_loaded", 64'(out_valid4), 64'h1);
    in_valid4 = 4'b0000; #1;
    check("t5_no_pop", 64'(in_ready4), 64'h0);
    tick();
    check("t5_drained", 64'(out_valid4), 64'h0);
    check("t5_stale_data", 64'(out_data4), 64'(word4(0)));
    check("t5_idle_ready", 64'(in_ready4), 64'h0);

    // Stall counter saturation, then mid-transfer reset.
    do_reset();
    in_valid4 = 4'b0001;
    tick();
    out_ready4 = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    check("t6_sat_stalls", 64'(perf_stalls4), 64'd15);
    check("t6_held_valid", 64'(out_valid4), 64'h1);
    reset = 1'b0; in_valid4 = 4'b1111; #1;
    check("t6_rst_ready", 64'(in_ready4), 64'h0);
    tick();
    check("t6_rst_valid", 64'(out_valid4), 64'h0);
    check("t6_rst_stalls", 64'(perf_stalls4), 64'h0);
    check("t6_rst_issued", 64'(perf_issued4), 64'h0);
    reset = 1'b1; out_ready4 = 1'b1; #1;
    check("t6_rst_ptr", 64'(in_ready4), 64'b0001);

    // Non-power-of-two warp count.
    in_valid4 = '0;
    do_reset();
    in_valid3 = 3'b111; #1;
    check("t4_first_ready", 64'(in_ready3), 64'b001);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t4_rr_wis", 64'(out_wis3), 64'(k % 3));
    end
    in_valid3 = 3'b100;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t4_only2_wis", 64'(out_wis3), 64'd2);
      check("t4_only2_data", 64'(out_data3), 64'h33);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vx_ibuffer_issue_sched.md
Name: vx_ibuffer_issue_sched

Overview:
Round-robin scheduler that shares one issue slice's scalar ibuffer output channel among the per-warp instruction buffers of that slice.
- Each cycle it selects one eligible warp (valid instruction and not masked by scoreboard/barrier logic).
- It pops that warp's instruction into a registered output stage and presents it downstream on a valid/ready channel with the warp index attached.
- Sits between the per-warp ibuffer queues and the issue/dispatch stage; one instance per issue slice.

Parameters:
NUM_WIS, 4, warps per issue slice (warp count / issue width); ≥1, need not be a power of two
DATA_W, 128, width of one packed ibuffer instruction record (opaque to this block)
WIS_W, LOG2UP(NUM_WIS), warp-index width; derived, not overridden
PERF_W, 32, width of the saturating performance counters

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active-low (asserted when 0)
in_valid  in  NUM_WIS  per-warp ibuffer head valid
in_data  in  NUM_WIS*DATA_W  per-warp head record; warp i occupies bits [i*DATA_W +: DATA_W]
in_ready  out  NUM_WIS  per-warp pop strobe (one-hot or zero)
wis_mask  in  NUM_WIS  1 = warp eligible this cycle
out_valid  out  1  registered output valid
out_data  out  DATA_W  registered instruction record
out_wis  out  WIS_W  warp index of out_data
out_ready  in  1  downstream accept
perf_issued  out  PERF_W  count of output handshakes
perf_stalls  out  PERF_W  count of cycles with out_valid=1 and out_ready=0

Behaviour:
Reset (reset=0 at a clk edge):
- out_valid=0; out_data=0; out_wis=0; rr_ptr=0; both perf counters=0.
- in_ready is forced to all-zero during reset.
- Reset mid-transfer discards the held record; no pop occurs in that cycle.

Selection:
- eligible = in_valid & wis_mask.
- The grant g is the first eligible index scanning rr_ptr, rr_ptr+1, … modulo NUM_WIS.
- The scan wraps cyclically, including for non-power-of-two NUM_WIS (e.g. 3: 2→0).

Load condition:
- load = (!out_valid || out_ready) && |eligible.
- in_ready[g] = load; all other in_ready bits = 0.
- in_ready is purely combinational from in_valid, wis_mask, out_valid, out_ready and rr_ptr. It never depends on in_data.

On load (next edge):
- out_data <= in_data[g]; out_wis <= g; out_valid <= 1.
- rr_ptr <= (g+1) mod NUM_WIS.

Output hold and drain:
- If out_valid && out_ready && !|eligible: out_valid <= 0, and out_data/out_wis keep their stale values.
- If out_valid && !out_ready: out_valid, out_data and out_wis are held stable, no pop occurs, and rr_ptr is unchanged.

Latency and throughput:
- 1 cycle from pop to out_valid.
- Sustained throughput of 1 instruction/cycle while out_ready=1 and some warp is eligible. A simultaneous handshake and load in one cycle is required.

Masking:
- wis_mask applies only at selection.
- A record already in the output register is never revoked by a later mask change.

Fairness:
- Any warp that stays eligible is granted within NUM_WIS loads.
- rr_ptr moves only on load.

Performance counters:
- perf_issued increments on out_valid && out_ready.
- perf_stalls increments on out_valid && !out_ready.
- Both saturate at 2^PERF_W-1 (no wrap).

Degenerate case NUM_WIS=1:
- WIS_W=1; out_wis is always 0; rr_ptr is constant 0.

Test Plan:
1. Reset and idle: hold reset=0 for 2 cycles with all in_valid=1 → in_ready=0000, out_valid=0, counters=0. Release with all valid, mask=1111, out_ready=1 → out_wis sequence 0,1,2,3,0 on consecutive cycles, and perf_issued=5 after 5 handshakes.
2. Backpressure: load warp 2, then out_ready=0 for 3 cycles → out_data/out_wis=2 held constant, in_ready=0000, perf_stalls=3. Raise out_ready → handshake, and warp 3 loaded in the same cycle.
3. Mask and pointer wrap: rr_ptr=1, in_valid=1111, wis_mask=0001 → grant 0, rr_ptr→1. Then mask=1111 → grant 1.
4. Non-power-of-two: NUM_WIS=3, all eligible, out_ready=1 → out_wis 0,1,2,0,1. Only warp 2 valid for 3 cycles → 3 consecutive grants to 2.
5. Drain: single record loaded, all in_valid=0, out_ready=1 → out_valid falls next cycle, with no spurious in_ready.
6. Reset mid-operation and saturation: with PERF_W=4 and out_valid=1, out_ready=0 for 20 cycles → perf_stalls=15. Then reset=0 → out_valid=0, rr_ptr=0, and counters=0 on the next edge.
